// File: rtl/led_matrix_scan.sv
// -----------------------------------------------------------------------------
// led_matrix_scan
//
// Purpose:
//    Scan engine for a ROWS x COLS LED matrix driven through external column and
//    row shift registers. A row-addressed framebuffer is written through a simple
//    row-write port and continuously multiplexed onto the matrix, one row per
//    visit of BLANK -> SHIFT_COL -> SHIFT_ROW -> LATCH -> DISPLAY.
//
// Configuration macro:
//    DOUBLE_BUFFER_EN - when defined, two framebuffers are kept: the scan reads
//                       the front buffer, the write port fills the back buffer,
//                       and a requested swap takes effect at the end of a frame.
//                       When undefined, a single buffer is both written and
//                       scanned, swap is ignored and swap_done is tied low.
//
// Parameters:
//    COLS     columns per row, also the column shift-register length (>=2)
//    ROWS     rows scanned per frame (>=2)
//    CLK_DIV  clk cycles per half shift-clock period (>=1)
//    DWELL    clk cycles each row is lit (>=1)
//
// Ports:
//    clk          system clock
//    reset        synchronous, active-high reset
//    wr_en        write wr_data into row wr_row this cycle
//    wr_row       target row; values >= ROWS are ignored
//    wr_data      row pixels, bit c = column c, 1 = lit
//    swap         buffer swap request (double-buffer build only)
//    swap_done    one-cycle pulse when a swap takes effect
//    frame_start  one-cycle pulse while row 0 is in BLANK
//    CCLK, CSDI   column shift clock / serial data
//    RCLK, RSDI   row shift clock / serial data
//    LE           latch enable for column and row registers
//    OEB          output enable, active low
//
// All pin outputs are registered decodes of the FSM state, so they appear one
// cycle after the internal state that produces them and are glitch-free.
// -----------------------------------------------------------------------------
module led_matrix_scan #(
   parameter  int COLS    = 16,
   parameter  int ROWS    = 16,
   parameter  int CLK_DIV = 1,
   parameter  int DWELL   = 256,
   localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [RW-1:0]   wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            swap,
   output logic            swap_done,
   output logic            frame_start,
   output logic            CCLK,
   output logic            CSDI,
   output logic            RCLK,
   output logic            RSDI,
   output logic            LE,
   output logic            OEB
);

   localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BITW = $clog2(COLS);
   localparam int DWW  = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(CLK_DIV - 1);
   localparam logic [BITW-1:0] BIT_LAST   = BITW'(COLS - 1);
   localparam logic [DWW-1:0]  DWELL_LAST = DWW'(DWELL - 1);
   localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);

   typedef enum logic [2:0] {
      ST_BLANK,
      ST_SHIFT_COL,
      ST_SHIFT_ROW,
      ST_LATCH,
      ST_DISPLAY
   } state_t;

   // ------------------------------------------------------------------
   // Scan state
   // ------------------------------------------------------------------
   state_t          state_reg,     state_next;
   logic [RW-1:0]   row_reg,       row_next;
   logic [COLS-1:0] col_shift_reg, col_shift_next;
   logic [BITW-1:0] bit_cnt_reg,   bit_cnt_next;
   logic [DIVW-1:0] div_cnt_reg,   div_cnt_next;
   logic            half_reg,      half_next;     // 0 = shift clock low phase
   logic [DWW-1:0]  dwell_cnt_reg, dwell_cnt_next;

   logic            oeb_reg,  oeb_next;
   logic            cclk_reg, cclk_next;
   logic            csdi_reg, csdi_next;
   logic            rclk_reg, rclk_next;
   logic            rsdi_reg, rsdi_next;
   logic            le_reg,   le_next;
   logic            frame_start_reg, frame_start_next;

   logic            div_last;
   logic            dwell_last;

   // Row data as seen by the scan (front buffer in the double-buffer build).
   logic [COLS-1:0] front_rows [ROWS];

`ifdef DOUBLE_BUFFER_EN
   logic front_sel_reg,    front_sel_next;
   logic swap_pending_reg, swap_pending_next;
   logic swap_done_reg;
   logic frame_end;
   logic exchange;
`endif

   assign div_last   = (div_cnt_reg == DIV_LAST);
   assign dwell_last = (dwell_cnt_reg == DWELL_LAST);

   // ------------------------------------------------------------------
   // Framebuffer storage, one register set per row. Rows are cleared by
   // reset, so this is a register file rather than a block RAM. A wr_row
   // value of ROWS or above matches no row and is dropped naturally.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
         logic row_hit;
         assign row_hit = wr_en && (wr_row == RW'(gi));
`ifdef DOUBLE_BUFFER_EN
         logic [COLS-1:0] buf0_reg;
         logic [COLS-1:0] buf1_reg;
         // front_sel_reg = 0: buf0 is scanned, buf1 takes writes.
         always_ff @(posedge clk) begin
            if (reset) begin
               buf0_reg <= '0;
               buf1_reg <= '0;
            end else if (row_hit) begin
               if (front_sel_reg) begin
                  buf0_reg <= wr_data;
               end else begin
                  buf1_reg <= wr_data;
               end
            end
         end
         assign front_rows[gi] = front_sel_reg ? buf1_reg : buf0_reg;
`else
         logic [COLS-1:0] buf_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               buf_reg <= '0;
            end else if (row_hit) begin
               buf_reg <= wr_data;
            end
         end
         assign front_rows[gi] = buf_reg;
`endif
      end
   endgenerate

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_BLANK;
         row_reg         <= '0;
         col_shift_reg   <= '0;
         bit_cnt_reg     <= '0;
         div_cnt_reg     <= '0;
         half_reg        <= 1'b0;
         dwell_cnt_reg   <= '0;
         oeb_reg         <= 1'b1;
         cclk_reg        <= 1'b0;
         csdi_reg        <= 1'b0;
         rclk_reg        <= 1'b0;
         rsdi_reg        <= 1'b0;
         le_reg          <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         row_reg         <= row_next;
         col_shift_reg   <= col_shift_next;
         bit_cnt_reg     <= bit_cnt_next;
         div_cnt_reg     <= div_cnt_next;
         half_reg        <= half_next;
         dwell_cnt_reg   <= dwell_cnt_next;
         oeb_reg         <= oeb_next;
         cclk_reg        <= cclk_next;
         csdi_reg        <= csdi_next;
         rclk_reg        <= rclk_next;
         rsdi_reg        <= rsdi_next;
         le_reg          <= le_next;
         frame_start_reg <= frame_start_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      row_next       = row_reg;
      col_shift_next = col_shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      div_cnt_next   = div_cnt_reg;
      half_next      = half_reg;
      dwell_cnt_next = dwell_cnt_reg;

      case (state_reg)
         ST_BLANK: begin
            // Snapshot of the row; a write landing on this same edge is
            // not captured (the read sees the pre-write contents).
            col_shift_next = front_rows[row_reg];
            bit_cnt_next   = BIT_LAST;
            div_cnt_next   = '0;
            half_next      = 1'b0;
            dwell_cnt_next = '0;
            state_next     = ST_SHIFT_COL;
         end

         ST_SHIFT_COL: begin
            if (div_last) begin
               div_cnt_next = '0;
               half_next    = ~half_reg;
               // Data advances on the high->low transition, so CSDI only
               // moves while CCLK is low.
               if (half_reg) begin
                  if (bit_cnt_reg == '0) begin
                     state_next = ST_SHIFT_ROW;
                  end else begin
                     bit_cnt_next   = bit_cnt_reg - BITW'(1);
                     col_shift_next = {col_shift_reg[COLS-2:0], 1'b0};
                  end
               end
            end else begin
               div_cnt_next = div_cnt_reg + DIVW'(1);
            end
         end

         ST_SHIFT_ROW: begin
            if (div_last) begin
               div_cnt_next = '0;
               half_next    = ~half_reg;
               if (half_reg) begin
                  state_next = ST_LATCH;
               end
            end else begin
               div_cnt_next = div_cnt_reg + DIVW'(1);
            end
         end

         ST_LATCH: begin
            if (div_last) begin
               div_cnt_next = '0;
               state_next   = ST_DISPLAY;
            end else begin
               div_cnt_next = div_cnt_reg + DIVW'(1);
            end
         end

         ST_DISPLAY: begin
            if (dwell_last) begin
               dwell_cnt_next = '0;
               // Explicit wrap so non-power-of-2 ROWS never reaches ROWS.
               row_next       = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
               state_next     = ST_BLANK;
            end else begin
               dwell_cnt_next = dwell_cnt_reg + DWW'(1);
            end
         end

         default: begin
            state_next = ST_BLANK;
         end
      endcase

      // Pin decode of the current state, registered on the next edge.
      oeb_next         = (state_reg != ST_DISPLAY);
      cclk_next        = (state_reg == ST_SHIFT_COL) && half_reg;
      csdi_next        = (state_reg == ST_SHIFT_COL) && col_shift_reg[COLS-1];
      rclk_next        = (state_reg == ST_SHIFT_ROW) && half_reg;
      rsdi_next        = (state_reg == ST_SHIFT_ROW) && (row_reg == '0);
      le_next          = (state_reg == ST_LATCH);
      frame_start_next = (state_reg == ST_BLANK) && (row_reg == '0);
   end

   // ------------------------------------------------------------------
   // Buffer swap control
   // ------------------------------------------------------------------
`ifdef DOUBLE_BUFFER_EN
   // Last DISPLAY cycle of the last row: the next BLANK reads row 0 of the
   // new front buffer.
   assign frame_end = (state_reg == ST_DISPLAY) && dwell_last && (row_reg == ROW_LAST);
   assign exchange  = frame_end && swap_pending_reg;

   always_comb begin
      front_sel_next    = front_sel_reg ^ exchange;
      // A request arriving in the exchange cycle becomes the next pending one.
      swap_pending_next = exchange ? swap : (swap_pending_reg | swap);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         front_sel_reg    <= 1'b0;
         swap_pending_reg <= 1'b0;
         swap_done_reg    <= 1'b0;
      end else begin
         front_sel_reg    <= front_sel_next;
         swap_pending_reg <= swap_pending_next;
         swap_done_reg    <= exchange;
      end
   end

   assign swap_done = swap_done_reg;
`else
   logic unused_swap;
   assign unused_swap = swap;
   assign swap_done   = 1'b0;
`endif

   assign OEB         = oeb_reg;
   assign CCLK        = cclk_reg;
   assign CSDI        = csdi_reg;
   assign RCLK        = rclk_reg;
   assign RSDI        = rsdi_reg;
   assign LE          = le_reg;
   assign frame_start = frame_start_reg;

endmodule
